// File: rtl/vga_ball_engine.sv
// VGA timing generator with a bouncing square ball, registered sync/colour outputs and frame/bounce events.
// Optional border ring is compiled in when VGA_BORDER_EN is defined.
module vga_ball_engine #(
    parameter int          CLK_DIV   = 4,
    parameter int          H_DISPLAY = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_DISPLAY = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int          COORD_W   = 10,
    parameter int          BALL_SIZE = 10,
    parameter int          BALL_X0   = 100,
    parameter int          BALL_Y0   = 200,
    parameter logic [11:0] BALL_RGB  = 12'hFFF,
    parameter logic [11:0] BG_RGB    = 12'h000
`ifdef VGA_BORDER_EN
    ,
    parameter int          BORDER_W   = 4,
    parameter logic [11:0] BORDER_RGB = 12'h00F
`endif
) (
    input  logic       clk100MHz,
    input  logic       reset,
    input  logic       pause,
    input  logic [3:0] speed_x,
    input  logic [3:0] speed_y,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frame_tick,
    output logic       bounce
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW1     = COORD_W + 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [COORD_W-1:0] X_RESET  = COORD_W'(BALL_X0);
    localparam logic [COORD_W-1:0] Y_RESET  = COORD_W'(BALL_Y0);
    localparam logic [CW1-1:0]     X_MAX    = CW1'(H_DISPLAY - BALL_SIZE);
    localparam logic [CW1-1:0]     Y_MAX    = CW1'(V_DISPLAY - BALL_SIZE);
    localparam logic [CW1-1:0]     SIZE_EXT = CW1'(BALL_SIZE);

    typedef struct packed {
        logic               hit;
        logic               dir;
        logic [COORD_W-1:0] pos;
    } axis_t;

    // One axis of ball motion; dir 0 = increasing, 1 = decreasing. Clamps at the wall instead of wrapping.
    function automatic axis_t step_axis(input logic [COORD_W-1:0] pos, input logic dir,
                                        input logic [3:0] speed, input logic [CW1-1:0] limit);
        axis_t          r;
        logic [CW1-1:0] pos_w;
        logic [CW1-1:0] spd_w;
        logic [CW1-1:0] sum;
        pos_w = {1'b0, pos};
        spd_w = CW1'(speed);
        sum   = pos_w + spd_w;
        r.hit = 1'b0;
        r.dir = dir;
        r.pos = pos;
        if (speed != 4'd0) begin
            if (!dir) begin
                if (sum >= limit) begin
                    r.pos = limit[COORD_W-1:0];
                    r.dir = 1'b1;
                    r.hit = 1'b1;
                end else begin
                    r.pos = sum[COORD_W-1:0];
                end
            end else if (pos_w <= spd_w) begin
                r.pos = '0;
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - COORD_W'(speed);
            end
        end
        return r;
    endfunction

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] h_cnt, v_cnt;
    logic [COORD_W-1:0] ball_x, ball_y;
    logic               dir_x, dir_y;
    logic               pix_en, frame_start, visible, in_ball;
    logic [11:0]        rgb_next;
    axis_t              next_x, next_y;

    assign pix_en      = (div_cnt == DIV_LAST);
    assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == '0);
    assign visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign in_ball     = (h_cnt >= ball_x) && ({1'b0, h_cnt} < ({1'b0, ball_x} + SIZE_EXT)) &&
                         (v_cnt >= ball_y) && ({1'b0, v_cnt} < ({1'b0, ball_y} + SIZE_EXT));
    assign next_x      = step_axis(ball_x, dir_x, speed_x, X_MAX);
    assign next_y      = step_axis(ball_y, dir_y, speed_y, Y_MAX);

`ifdef VGA_BORDER_EN
    localparam logic [COORD_W-1:0] B_W   = COORD_W'(BORDER_W);
    localparam logic [COORD_W-1:0] B_RGT = COORD_W'(H_DISPLAY - BORDER_W);
    localparam logic [COORD_W-1:0] B_BOT = COORD_W'(V_DISPLAY - BORDER_W);
    logic in_border;
    assign in_border = (h_cnt < B_W) || (h_cnt >= B_RGT) || (v_cnt < B_W) || (v_cnt >= B_BOT);
`endif

    always_comb begin
        rgb_next = BG_RGB;
        if (!visible) begin
            rgb_next = '0;
        end else if (in_ball) begin
            rgb_next = BALL_RGB;
        end
`ifdef VGA_BORDER_EN
        else if (in_border) begin
            rgb_next = BORDER_RGB;
        end
`endif
    end

    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + DIV_W'(1);
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + COORD_W'(1);
                end else begin
                    h_cnt <= h_cnt + COORD_W'(1);
                end
            end
        end
    end

    // Position only moves at the frame boundary, so a whole frame is drawn from one position.
    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            ball_x     <= X_RESET;
            ball_y     <= Y_RESET;
            dir_x      <= 1'b0;
            dir_y      <= 1'b0;
            frame_tick <= 1'b0;
            bounce     <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            bounce     <= frame_start && !pause && (next_x.hit || next_y.hit);
            if (frame_start && !pause) begin
                ball_x <= next_x.pos;
                ball_y <= next_y.pos;
                dir_x  <= next_x.dir;
                dir_y  <= next_y.dir;
            end
        end
    end

    always_ff @(posedge clk100MHz or negedge reset) begin
        if (!reset) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            {red, green, blue} <= '0;
        end else if (pix_en) begin
            hsync <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            {red, green, blue} <= rgb_next;
        end
    end

endmodule
